// File: rtl/muldiv_unit_if.sv
// Start/done handshake bundle between the EX-stage controller (master)
// and the iterative multiply/divide unit (slave).
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] res;

    modport master (
        output start, flush, op, op_a, op_b,
        input  busy, done, res
    );

    modport slave (
        input  start, flush, op, op_a, op_b,
        output busy, done, res
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on unsigned magnitudes, one bit per cycle, with a final sign fix-up.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   res_q;

    logic              is_div;
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic              res_neg;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic              accept;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   special_res;

    assign is_div   = bus.op[2];
    assign a_signed = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
    assign b_signed = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
    assign a_neg    = a_signed && bus.op_a[XLEN-1];
    assign b_neg    = b_signed && bus.op_b[XLEN-1];
    assign a_mag    = a_neg ? -bus.op_a : bus.op_a;
    assign b_mag    = b_neg ? -bus.op_b : bus.op_b;
    // Remainder follows the dividend sign; everything else is the sign product.
    assign res_neg  = (is_div && bus.op[1]) ? a_neg : (a_neg ^ b_neg);

    assign div_zero = is_div && (bus.op_b == {XLEN{1'b0}});
    assign div_ovf  = is_div && !bus.op[0] && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.op_b == {XLEN{1'b1}});
    assign special  = div_zero || div_ovf;
    assign special_res = div_zero ? (bus.op[1] ? bus.op_a : {XLEN{1'b1}})
                                  : (bus.op[1] ? {XLEN{1'b0}} : bus.op_a);

    assign accept = bus.start && !bus.flush && ((state == IDLE) || (state == DONE));

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [2*XLEN-1:0] mul_step;
    logic [2*XLEN-1:0] div_step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    // acc holds {high product, multiplier} for multiply, {remainder, dividend/quotient} for divide.
    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    assign mul_step  = {mul_sum, acc[XLEN-1:1]};
    assign div_shift = acc[2*XLEN-1:XLEN-1];
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_sub   = div_shift[XLEN-1:0] - opnd;
    assign div_step  = {div_ge ? div_sub : div_shift[XLEN-1:0], acc[XLEN-2:0], div_ge};

    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fix  = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        fix_res = prod_fix[XLEN-1:0];
        case (op_q)
            3'd1, 3'd2, 3'd3: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fix_res = quo_fix;
            3'd6, 3'd7:       fix_res = rem_fix;
            default:          fix_res = prod_fix[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: begin
                bus.busy = 1'b1;
                if (cnt == CW'(1)) state_next = FIX;
            end
            FIX: begin
                bus.busy   = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = accept ? (special ? DONE : CALC) : IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (bus.flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        // NOTE: the datapath is a handful of registers, not a memory, so all of it is cleared on reset.
        if (rst) begin
            op_q  <= 3'd0;
            neg_q <= 1'b0;
            cnt   <= {CW{1'b0}};
            opnd  <= {XLEN{1'b0}};
            acc   <= {(2*XLEN){1'b0}};
            res_q <= {XLEN{1'b0}};
        end else if (accept) begin
            op_q  <= bus.op;
            neg_q <= res_neg;
            cnt   <= CW'(XLEN);
            opnd  <= is_div ? b_mag : a_mag;
            acc   <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
            if (special) res_q <= special_res;
        end else if (!bus.flush) begin
            if (state == CALC) begin
                cnt <= cnt - CW'(1);
                acc <= op_q[2] ? div_step : mul_step;
            end else if (state == FIX) begin
                res_q <= fix_res;
            end
        end
    end

    assign bus.res = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases and control
// scenarios at XLEN=32, plus a reference-model sweep at XLEN=16.
module tb_muldiv_unit;
    localparam int W32 = 32;
    localparam int W16 = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_unit_if #(.XLEN(W32)) bus32 ();
    muldiv_unit_if #(.XLEN(W16)) bus16 ();

    muldiv_unit #(.XLEN(W32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    muldiv_unit #(.XLEN(W16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    typedef struct {
        logic [31:0] val;
        int          at;
        string       tag;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    exp_t e32;
    exp_t e16;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] width_mask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic bit is_special(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] m;
        m = width_mask(w);
        if (!op[2]) return 1'b0;
        if ((64'(b) & m) == 64'd0) return 1'b1;
        return (op == 3'd4 || op == 3'd6) && ((64'(a) & m) == (64'd1 << (w - 1))) && ((64'(b) & m) == m);
    endfunction

    // Reference model: plain wide arithmetic on sign-extended or zero-extended operands.
    function automatic logic [31:0] model(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] m, ua, ub, p, r;
        longint      sa, sb;
        m  = width_mask(w);
        ua = 64'(a) & m;
        ub = 64'(b) & m;
        sa = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        r  = 64'd0;
        case (op)
            3'd0: begin p = ua * ub;          r = p; end
            3'd1: begin p = 64'(sa * sb);     r = p >> w; end
            3'd2: begin p = 64'(sa) * ub;     r = p >> w; end
            3'd3: begin p = ua * ub;          r = p >> w; end
            3'd4: if (ub == 0) r = m;
                  else if (is_special(w, op, a, b)) r = ua;
                  else r = 64'(sa / sb);
            3'd5: r = (ub == 0) ? m : ua / ub;
            3'd6: if (ub == 0) r = ua;
                  else if (is_special(w, op, a, b)) r = 64'd0;
                  else r = 64'(sa % sb);
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(r & m);
    endfunction

    always @(negedge clk) begin
        if (bus32.done) begin
            check("busy_done_excl32", 64'(bus32.busy), 64'd0);
            check("sb_expect32", 64'(q32.size()), 64'd1);
            if (q32.size() != 0) begin
                e32 = q32.pop_front();
                check(e32.tag, 64'(bus32.res), 64'(e32.val));
                check({e32.tag, "_cycle"}, 64'(cyc), 64'(e32.at));
            end
        end
        if (bus16.done) begin
            check("busy_done_excl16", 64'(bus16.busy), 64'd0);
            check("sb_expect16", 64'(q16.size()), 64'd1);
            if (q16.size() != 0) begin
                e16 = q16.pop_front();
                check(e16.tag, 64'(bus16.res), 64'(e16.val));
                check({e16.tag, "_cycle"}, 64'(cyc), 64'(e16.at));
            end
        end
    end

    task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input string tag, input bit track);
        exp_t e;
        bus32.op    = op;
        bus32.op_a  = a;
        bus32.op_b  = b;
        bus32.start = 1'b1;
        if (track) begin
            e.val = exp;
            e.at  = cyc + (is_special(W32, op, a, b) ? 1 : W32 + 2);
            e.tag = tag;
            q32.push_back(e);
        end
        @(posedge clk); #1;
        bus32.start = 1'b0;
    endtask

    task automatic wait32(output int busy_n);
        busy_n = 0;
        for (int i = 0; i < 200 && q32.size() != 0; i++) begin
            @(negedge clk); #1;
            if (bus32.busy) busy_n++;
        end
        if (q32.size() != 0) begin
            check("timeout32", 64'(q32.size()), 64'd0);
            q32.delete();
        end
    endtask

    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        int n;
        issue32(op, a, b, exp, tag, 1'b1);
        wait32(n);
        @(posedge clk); #1;
    endtask

    task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input string tag);
        exp_t e;
        bus16.op    = op;
        bus16.op_a  = a;
        bus16.op_b  = b;
        bus16.start = 1'b1;
        e.val = model(W16, op, 32'(a), 32'(b));
        e.at  = cyc + (is_special(W16, op, 32'(a), 32'(b)) ? 1 : W16 + 2);
        e.tag = tag;
        q16.push_back(e);
        @(posedge clk); #1;
        bus16.start = 1'b0;
        for (int i = 0; i < 100 && q16.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        if (q16.size() != 0) begin
            check("timeout16", 64'(q16.size()), 64'd0);
            q16.delete();
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(5))
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return 16'hFFFF;
            3:       return 16'h8000;
            4:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        {bus32.start, bus32.flush, bus32.op, bus32.op_a, bus32.op_b} = '0;
        {bus16.start, bus16.flush, bus16.op, bus16.op_a, bus16.op_b} = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy32", 64'(bus32.busy), 64'd0);
        check("reset_done32", 64'(bus32.done), 64'd0);
        check("reset_res32", 64'(bus32.res), 64'd0);
        check("reset_res16", 64'(bus16.res), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        issue32(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul", 1'b1);
        wait32(n);
        check("mul_busy_cycles", 64'(n), 64'(W32 + 1));
        @(posedge clk); #1;

        run32(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
        run32(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
        run32(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
        run32(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_neg");
        run32(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_neg");
        run32(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_by0");
        run32(3'd6, 32'd5, 32'd0, 32'd5, "rem_by0");
        run32(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        run32(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem_ovf");
        run32(3'd5, 32'd100, 32'd7, 32'd14, "divu");
        run32(3'd7, 32'd100, 32'd7, 32'd2, "remu");

        // Flush mid-divide: no done, result register untouched.
        issue32(3'd4, 32'hFFFF0000, 32'd3, 32'd0, "", 1'b0);
        repeat (9) @(posedge clk);
        #1;
        bus32.flush = 1'b1;
        @(posedge clk); #1;
        bus32.flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(bus32.busy), 64'd0);
        check("flush_done", 64'(bus32.done), 64'd0);
        repeat (40) @(negedge clk);
        check("flush_res_hold", 64'(bus32.res), 64'd2);
        @(posedge clk); #1;

        // Start and flush together: flush wins.
        bus32.op    = 3'd0;
        bus32.op_a  = 32'd3;
        bus32.op_b  = 32'd3;
        bus32.start = 1'b1;
        bus32.flush = 1'b1;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        bus32.flush = 1'b0;
        @(negedge clk);
        check("start_flush_busy", 64'(bus32.busy), 64'd0);
        check("start_flush_done", 64'(bus32.done), 64'd0);
        repeat (40) @(negedge clk);
        check("start_flush_res", 64'(bus32.res), 64'd2);
        @(posedge clk); #1;

        // Start while busy is ignored.
        issue32(3'd0, 32'd3, 32'd5, 32'd15, "mul_ignore_start", 1'b1);
        repeat (5) @(posedge clk);
        #1;
        bus32.op    = 3'd5;
        bus32.op_a  = 32'd9;
        bus32.op_b  = 32'd3;
        bus32.start = 1'b1;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        wait32(n);
        repeat (40) @(negedge clk);
        @(posedge clk); #1;

        // Reset in the middle of an operation clears all outputs on the next cycle.
        issue32(3'd5, 32'd1000, 32'd3, 32'd0, "", 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(bus32.busy), 64'd0);
        check("rst_done", 64'(bus32.done), 64'd0);
        check("rst_res", 64'(bus32.res), 64'd0);
        repeat (40) @(negedge clk);
        @(posedge clk); #1;

        // Back-to-back: second start lands in the DONE cycle of the first.
        issue32(3'd0, 32'd6, 32'd7, 32'd42, "b2b_first", 1'b1);
        wait32(n);
        issue32(3'd5, 32'd1000, 32'd10, 32'd100, "b2b_second", 1'b1);
        wait32(n);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            rop = 3'($urandom_range(7));
            ra  = $urandom;
            rb  = (i % 4 == 0) ? 32'd0 : $urandom;
            run32(rop, ra, rb, model(W32, rop, ra, rb), "rand32");
        end

        for (int i = 0; i < 64; i++) begin
            run16(3'(i % 8), pick16(), pick16(), "rand16");
        end

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
